// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared FSM encoding and default sizes for the UART transmit feeder
package uart_tx_feeder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } feeder_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH_LOG2 = 4;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// rtl/uart_tx_feeder_sync_fifo.sv - single-clock FIFO with registered level and level-decoded flags
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     pop_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0]   DEPTH_V   = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (level == DEPTH_V);
  assign empty    = (level == '0);
  // A full FIFO refuses writes even when a pop lands in the same cycle.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers system writes and feeds frames to the UART transmit control stage
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                clr_overflow,
  input  logic                tx_done_sig,
  output logic                tx_en_sig,
  output logic [DATA_W-1:0]   tx_data,
  output logic                busy
);

  feeder_state_t     state;
  feeder_state_t     state_nxt;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        // A word written during the done cycle is not visible yet; restart from IDLE.
        if (tx_done_sig) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) tx_data <= head_data;
      if (clr_overflow)       overflow <= 1'b0;
      else if (wr_en && full) overflow <= 1'b1;
    end
  end

  assign tx_en_sig = (state == ST_SEND);
  assign busy      = tx_en_sig | ~empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic       tx_done_sig;
  logic       tx_en_sig;
  logic [7:0] tx_data;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_feeder #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx_done_sig  (tx_done_sig),
    .tx_en_sig    (tx_en_sig),
    .tx_data      (tx_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0; tx_done_sig = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'hC3; tick();
    wr_data = 8'h3C; tick();
    wr_en = 1'b1; tick();
    wr_en = 1'b0; tick();
    n_cmp++;
    if (tx_en_sig !== 1'b1) begin n_bad++; $display("FAIL reset_pre_tx_en: got %0b want 1", tx_en_sig); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_en_sig, busy, full, overflow} !== 4'b0000 || empty !== 1'b1 || level !== 5'd0 || tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_async: got en=%0b busy=%0b full=%0b ovf=%0b empty=%0b level=%0d data=%h want 0 0 0 0 1 0 00",
               tx_en_sig, busy, full, overflow, empty, level, tx_data);
    end
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (tx_en_sig !== 1'b0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL reset_idle_after: got en=%0b empty=%0b want 0 1", tx_en_sig, empty);
    end
  endtask

  task automatic test_single_byte();
    wr_en = 1'b1; wr_data = 8'h55; tick();
    wr_en = 1'b0;
    n_cmp++;
    if (empty !== 1'b0 || tx_en_sig !== 1'b0) begin
      n_bad++; $display("FAIL single_edge1: got empty=%0b en=%0b want 0 0", empty, tx_en_sig);
    end
    tick();
    n_cmp++;
    if (tx_en_sig !== 1'b1 || tx_data !== 8'h55 || empty !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_edge2: got en=%0b data=%h empty=%0b busy=%0b want 1 55 1 1", tx_en_sig, tx_data, empty, busy);
    end
    tick();
    tx_done_sig = 1'b1; tick();
    tx_done_sig = 1'b0;
    n_cmp++;
    if (tx_en_sig !== 1'b0 || empty !== 1'b1 || busy !== 1'b0 || tx_data !== 8'h55) begin
      n_bad++; $display("FAIL single_done: got en=%0b empty=%0b busy=%0b data=%h want 0 1 0 55", tx_en_sig, empty, busy, tx_data);
    end
  endtask

  task automatic test_burst();
    logic [4:0] peak;
    peak = '0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1); tick();
      if (level > peak) peak = level;
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 3; h++) begin
        if (level > peak) peak = level;
        n_cmp++;
        if (tx_en_sig !== 1'b1 || tx_data !== 8'(k + 1)) begin
          n_bad++; $display("FAIL burst_frame%0d_hold%0d: got en=%0b data=%h want 1 %h", k, h, tx_en_sig, tx_data, 8'(k + 1));
        end
        tick();
      end
      tx_done_sig = 1'b1; tick();
      tx_done_sig = 1'b0;
    end
    n_cmp++;
    if (tx_en_sig !== 1'b0 || tx_data !== 8'h04) begin
      n_bad++; $display("FAIL burst_end: got en=%0b data=%h want 0 04", tx_en_sig, tx_data);
    end
    n_cmp++;
    if (peak !== 5'd3) begin n_bad++; $display("FAIL burst_peak_level: got %0d want 3", peak); end
  endtask

  task automatic test_full_overflow_simul();
    logic [7:0] drain [5];
    drain[0] = 8'h1D; drain[1] = 8'h1E; drain[2] = 8'h1F; drain[3] = 8'h20; drain[4] = 8'h77;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i); tick();
    end
    wr_en = 1'b0;
    n_cmp++;
    if (level !== 5'd16 || full !== 1'b1 || tx_data !== 8'h10 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL full_17: got level=%0d full=%0b data=%h ovf=%0b want 16 1 10 0", level, full, tx_data, overflow);
    end
    wr_en = 1'b1; wr_data = 8'hDD; tick();
    wr_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      n_bad++; $display("FAIL overflow_set: got ovf=%0b level=%0d want 1 16", overflow, level);
    end
    clr_overflow = 1'b1; tick();
    clr_overflow = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL overflow_clr: got %0b want 0", overflow); end
    // pop and write while full: write dropped
    tx_done_sig = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; tick();
    tx_done_sig = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (level !== 5'd15 || overflow !== 1'b1 || tx_data !== 8'h11 || full !== 1'b0) begin
      n_bad++; $display("FAIL simul_full: got level=%0d ovf=%0b data=%h full=%0b want 15 1 11 0", level, overflow, tx_data, full);
    end
    clr_overflow = 1'b1; tick();
    clr_overflow = 1'b0;
    tx_done_sig = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    tx_done_sig = 1'b0;
    n_cmp++;
    if (level !== 5'd5 || tx_data !== 8'h1B) begin
      n_bad++; $display("FAIL drain_to_5: got level=%0d data=%h want 5 1b", level, tx_data);
    end
    tx_done_sig = 1'b1; wr_en = 1'b1; wr_data = 8'h77; tick();
    tx_done_sig = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (level !== 5'd5 || tx_data !== 8'h1C || overflow !== 1'b0) begin
      n_bad++; $display("FAIL simul_level5: got level=%0d data=%h ovf=%0b want 5 1c 0", level, tx_data, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      tx_done_sig = 1'b1; tick();
      tx_done_sig = 1'b0;
      n_cmp++;
      if (tx_data !== drain[i] || tx_en_sig !== 1'b1) begin
        n_bad++; $display("FAIL drain_order%0d: got data=%h en=%0b want %h 1", i, tx_data, tx_en_sig, drain[i]);
      end
    end
    tx_done_sig = 1'b1; tick();
    tx_done_sig = 1'b0;
    n_cmp++;
    if (tx_en_sig !== 1'b0 || empty !== 1'b1 || tx_data !== 8'h77) begin
      n_bad++; $display("FAIL drain_idle: got en=%0b empty=%0b data=%h want 0 1 77", tx_en_sig, empty, tx_data);
    end
  endtask

  task automatic test_done_into_empty();
    wr_en = 1'b1; wr_data = 8'h5A; tick();
    wr_en = 1'b0; tick();
    tick();
    tx_done_sig = 1'b1; wr_en = 1'b1; wr_data = 8'hA3; tick();
    tx_done_sig = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (tx_en_sig !== 1'b0 || empty !== 1'b0 || tx_data !== 8'h5A) begin
      n_bad++; $display("FAIL done_empty_idle: got en=%0b empty=%0b data=%h want 0 0 5a", tx_en_sig, empty, tx_data);
    end
    tick();
    n_cmp++;
    if (tx_en_sig !== 1'b1 || tx_data !== 8'hA3 || empty !== 1'b1) begin
      n_bad++; $display("FAIL done_empty_restart: got en=%0b data=%h empty=%0b want 1 a3 1", tx_en_sig, tx_data, empty);
    end
    tx_done_sig = 1'b1; tick();
    tx_done_sig = 1'b0;
    n_cmp++;
    if (tx_en_sig !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL done_empty_final: got en=%0b busy=%0b want 0 0", tx_en_sig, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_full_overflow_simul();
    test_done_into_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
